// File: rtl/im_port_arbiter.sv
// im_port_arbiter: shares one single-port instruction memory between the
// fetch stage (reads) and a program loader (single-word writes).
// At most one memory access per cycle; the grant is combinational from the
// requests and registered state. Fetch has priority over the loader.
// Optional build macro IM_ARB_FAIRNESS_EN: after RUN_LIMIT consecutive fetch
// grants with a waiting loader, the next contended cycle goes to the loader.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   f_req, Pc_F        fetch request and byte address
//   f_stall            fetch requested but not granted this cycle
//   f_valid, instr_F,  fetch result of the previous-cycle grant
//   f_err              previous fetch address out of range / misaligned
//   ld_req, ld_addr,   loader write request, byte address, data
//   ld_wdata
//   ld_ack, ld_err     loader request completed (rejected when ld_err)
//   mem_addr, mem_we,  memory address, write enable, write data
//   mem_wdata
//   mem_rdata          memory read data, one cycle after the address
module im_port_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter logic [31:0] TOP_ADDR  = 32'h0000_6FFC,
  parameter int unsigned RUN_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] Pc_F,
  output logic        f_stall,
  output logic        f_valid,
  output logic [31:0] instr_F,
  output logic        f_err,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ack,
  output logic        ld_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Last cycle's grant
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  if (RUN_LIMIT == 0) begin : g_bad_run_limit
    $error("RUN_LIMIT must be at least 1");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       fetch_bad;
  logic       fetch_bad_nxt;
  logic       f_legal;
  logic       ld_legal;
  logic       force_ld;
  logic       fetch_gnt;
  logic       ld_gnt;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a >= BASE_ADDR) && (a <= TOP_ADDR) && (a[1:0] == 2'b00);
  endfunction

  assign f_legal  = addr_legal(Pc_F);
  assign ld_legal = addr_legal(ld_addr);

`ifdef IM_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT + 1) : 1;

  logic [CNT_W-1:0] run_cnt;

  // Consecutive fetch grants while the loader waits; saturates at RUN_LIMIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (ld_gnt || !ld_req) begin
      run_cnt <= '0;
    end else if (fetch_gnt && (run_cnt != CNT_W'(RUN_LIMIT))) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  assign force_ld = ld_req && (run_cnt == CNT_W'(RUN_LIMIT));
`else
  assign force_ld = 1'b0;
`endif

  // Grant: nothing is granted while reset is held
  assign fetch_gnt = f_req && !reset && !force_ld;
  assign ld_gnt    = ld_req && !reset && !fetch_gnt;

  // State register; clearing it on reset discards any outstanding read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      fetch_bad <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_bad <= fetch_bad_nxt;
    end
  end

  // Next state, memory port and handshake outputs
  always_comb begin
    state_nxt     = S_IDLE;
    fetch_bad_nxt = 1'b0;
    mem_addr      = 32'h0;
    mem_we        = 1'b0;
    mem_wdata     = 32'h0;
    ld_ack        = 1'b0;
    ld_err        = 1'b0;
    f_stall       = f_req && !fetch_gnt;
    f_valid       = (state == S_FETCH);
    instr_F       = 32'h0;
    f_err         = 1'b0;

    // Result of last cycle's fetch; illegal fetches never touched memory
    if (state == S_FETCH) begin
      f_err = fetch_bad;
      if (!fetch_bad) begin
        instr_F = mem_rdata;
      end
    end

    if (fetch_gnt) begin
      state_nxt     = S_FETCH;
      fetch_bad_nxt = !f_legal;
      if (f_legal) begin
        mem_addr = Pc_F;
      end
    end else if (ld_gnt) begin
      state_nxt = S_LOAD;
      ld_ack    = 1'b1;
      ld_err    = !ld_legal;
      if (ld_legal) begin
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
    end
  end

endmodule
